// File: rtl/control_sumator_fp_pkg.sv
// Shared definitions for the floating-point adder sequencer: state encoding,
// default datapath geometry and the shift/normalization counter width.
package control_sumator_fp_pkg;

  localparam int CSF_EXP_W     = 8;
  localparam int CSF_MAX_SHIFT = 27;
  localparam int CSF_NORM_MAX  = 27;
  localparam int CSF_CNT_W     = $clog2(CSF_MAX_SHIFT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CMP   = 3'd2,
    ST_ALIGN = 3'd3,
    ST_ADD   = 3'd4,
    ST_NORM  = 3'd5,
    ST_WRITE = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  // Counter width able to hold the larger of the two step limits
  function automatic int cnt_width(input int max_shift, input int norm_max);
    int m;
    m = (max_shift > norm_max) ? max_shift : norm_max;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/control_sumator_fp_numarator_deplasare.sv
// Loadable down-counter for the alignment shift count. o_last flags the
// final shift cycle so the sequencer can leave ALIGN on that edge.
module numarator_deplasare
  import control_sumator_fp_pkg::*;
#(
  parameter int W = CSF_CNT_W
)(
  input  logic         clk,
  input  logic         clear_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; the count never wraps below zero
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/control_sumator_fp.sv
// Sequencer for the floating-point adder datapath:
// load -> compare -> align (1 bit/cycle) -> add -> normalize -> write -> done.
// Optional build macro ALIGN_FLUSH_EN: adds flush_small and skips the
// alignment loop when the exponent gap reaches MAX_SHIFT.
module control_sumator_fp
  import control_sumator_fp_pkg::*;
#(
  parameter int EXP_W     = CSF_EXP_W,
  parameter int MAX_SHIFT = CSF_MAX_SHIFT,
  parameter int NORM_MAX  = CSF_NORM_MAX
)(
  input  logic           clk,
  input  logic           clear_n,
  input  logic           start,
  input  logic [EXP_W:0] exp_diff,
  input  logic           special,
  input  logic           sum_zero,
  input  logic           sum_carry,
  input  logic           sum_msb,
  output logic           ld_ops,
  output logic           clr_mants,
  output logic           ld_mants,
  output logic           swap,
  output logic           shr_en,
  output logic           add_en,
  output logic           norm_shr,
  output logic           norm_shl,
  output logic           exp_inc,
  output logic           exp_dec,
  output logic           ld_result,
  output logic           busy,
`ifdef ALIGN_FLUSH_EN
  output logic           flush_small,
`endif
  output logic           done
);

  localparam int CNT_W = cnt_width(MAX_SHIFT, NORM_MAX);
  localparam logic [EXP_W:0] MAX_V   = (EXP_W + 1)'(MAX_SHIFT);
  localparam logic [CNT_W-1:0] NMAX_V = CNT_W'(NORM_MAX);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_swap;
  logic [CNT_W-1:0] r_norm_cnt;
  logic             r_ld_ops;
  logic             r_clr_mants;
  logic             r_shr_en;
  logic             r_add_en;
  logic             r_ld_result;
  logic             r_busy;
  logic             r_done;

  logic [EXP_W:0]   w_mag;
  logic [EXP_W:0]   w_sat;
  logic [CNT_W-1:0] w_shift_ld;
  logic             w_flush_go;
  logic             w_cnt_load;
  logic             w_cnt_last;
  logic             w_norm_exit;
  logic             w_shl;
  logic             w_shr;

  // Magnitude at full EXP_W+1 width: the most negative value maps to 2^EXP_W
  assign w_mag      = exp_diff[EXP_W] ? (~exp_diff + {{EXP_W{1'b0}}, 1'b1}) : exp_diff;
  assign w_sat      = (w_mag > MAX_V) ? MAX_V : w_mag;
  assign w_shift_ld = CNT_W'(w_sat);

`ifdef ALIGN_FLUSH_EN
  assign w_flush_go  = (w_mag >= MAX_V);
  assign flush_small = (r_state == ST_CMP) && !special && w_flush_go;
`else
  assign w_flush_go  = 1'b0;
`endif

  assign w_cnt_load = (r_state == ST_CMP) && !special && !w_flush_go;

  numarator_deplasare #(.W(CNT_W)) u_shift_cnt (
    .clk        (clk),
    .clear_n    (clear_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_shift_ld),
    .i_dec      (r_state == ST_ALIGN),
    .o_last     (w_cnt_last)
  );

  // Normalization decisions in flag priority order: zero, carry, msb, limit
  assign w_shr       = (r_state == ST_NORM) && !sum_zero && sum_carry;
  assign w_norm_exit = sum_zero || sum_carry || sum_msb || (r_norm_cnt == NMAX_V);
  assign w_shl       = (r_state == ST_NORM) && !w_norm_exit;

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_state_nxt = ST_CMP;
      ST_CMP: begin
        if (special) begin
          w_state_nxt = ST_WRITE;
        end else if (w_flush_go) begin
          w_state_nxt = ST_ADD;
        end else if (w_sat != '0) begin
          w_state_nxt = ST_ALIGN;
        end else begin
          w_state_nxt = ST_ADD;
        end
      end
      ST_ALIGN: w_state_nxt = w_cnt_last ? ST_ADD : ST_ALIGN;
      ST_ADD:   w_state_nxt = ST_NORM;
      ST_NORM:  w_state_nxt = w_norm_exit ? ST_WRITE : ST_NORM;
      ST_WRITE: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, swap memory, normalization count and registered Moore strobes
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= ST_IDLE;
      r_swap      <= 1'b0;
      r_norm_cnt  <= '0;
      r_ld_ops    <= 1'b0;
      r_clr_mants <= 1'b0;
      r_shr_en    <= 1'b0;
      r_add_en    <= 1'b0;
      r_ld_result <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == ST_CMP) begin
        r_swap <= exp_diff[EXP_W];
      end else if (w_state_nxt == ST_IDLE) begin
        r_swap <= 1'b0;
      end else begin
        r_swap <= r_swap;
      end

      if (r_state == ST_ADD) begin
        r_norm_cnt <= '0;
      end else if (w_shl) begin
        r_norm_cnt <= r_norm_cnt + CNT_W'(1);
      end else begin
        r_norm_cnt <= r_norm_cnt;
      end

      r_ld_ops    <= (w_state_nxt == ST_LOAD);
      r_clr_mants <= (w_state_nxt == ST_LOAD);
      r_shr_en    <= (w_state_nxt == ST_ALIGN);
      r_add_en    <= (w_state_nxt == ST_ADD);
      r_ld_result <= (w_state_nxt == ST_WRITE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign ld_ops    = r_ld_ops;
  assign clr_mants = r_clr_mants;
  assign shr_en    = r_shr_en;
  assign add_en    = r_add_en;
  assign ld_result = r_ld_result;
  assign busy      = r_busy;
  assign done      = r_done;

  assign swap      = (r_state == ST_CMP) ? exp_diff[EXP_W] : r_swap;
  assign ld_mants  = (r_state == ST_CMP) && !special;
  assign norm_shr  = w_shr;
  assign exp_inc   = w_shr;
  assign norm_shl  = w_shl;
  assign exp_dec   = w_shl;

endmodule

// File: tb/tb_control_sumator_fp.sv
// Scoreboard bench for control_sumator_fp: the stimulus side predicts each
// operation's strobe counts and latency from the arithmetic rules, a monitor
// accumulates what the DUT emits and compares on every done pulse.
module tb_control_sumator_fp;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       start;
  logic [8:0] exp_diff;
  logic       special, sum_zero, sum_carry, sum_msb;
  logic       ld_ops, clr_mants, ld_mants, swap, shr_en, add_en;
  logic       norm_shr, norm_shl, exp_inc, exp_dec, ld_result, busy, done;
`ifdef ALIGN_FLUSH_EN
  logic       flush_small;
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  control_sumator_fp dut (
    .clk(clk), .clear_n(clear_n), .start(start), .exp_diff(exp_diff),
    .special(special), .sum_zero(sum_zero), .sum_carry(sum_carry), .sum_msb(sum_msb),
    .ld_ops(ld_ops), .clr_mants(clr_mants), .ld_mants(ld_mants), .swap(swap),
    .shr_en(shr_en), .add_en(add_en), .norm_shr(norm_shr), .norm_shl(norm_shl),
    .exp_inc(exp_inc), .exp_dec(exp_dec), .ld_result(ld_result), .busy(busy),
`ifdef ALIGN_FLUSH_EN
    .flush_small(flush_small),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   done_cyc;
    int   shr;
    int   shl;
    int   nshr;
    int   add;
    int   ldm;
    logic swp;
    int   flush;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int cur_k = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Datapath stand-in: sum_msb rises once cur_k left shifts have been applied
  initial begin
    int  shl_seen;
    bit  a, s;
    shl_seen = 0;
    sum_msb  = 1'b0;
    forever begin
      @(negedge clk);
      a = add_en;
      s = norm_shl;
      @(posedge clk);
      #1;
      if (a) shl_seen = 0;
      else if (s) shl_seen++;
      sum_msb = (shl_seen >= cur_k);
    end
  end

  // Monitor: accumulate strobes per operation, compare on done
  initial begin
    int cyc, n_shr, n_shl, n_nshr, n_einc, n_edec, n_add, n_ldm, n_ldr, n_ldops, n_fl, n_both;
    bit sw_c1, sw_hi, sw_lo;
    exp_t e;
    cyc = 0; n_shr = 0; n_shl = 0; n_nshr = 0; n_einc = 0; n_edec = 0; n_add = 0;
    n_ldm = 0; n_ldr = 0; n_ldops = 0; n_fl = 0; n_both = 0; sw_c1 = 0; sw_hi = 0; sw_lo = 0;
    forever begin
      @(negedge clk);
      if (!clear_n || !busy) begin
        cyc = 0; n_shr = 0; n_shl = 0; n_nshr = 0; n_einc = 0; n_edec = 0; n_add = 0;
        n_ldm = 0; n_ldr = 0; n_ldops = 0; n_fl = 0; n_both = 0; sw_c1 = 0; sw_hi = 0; sw_lo = 0;
      end else begin
        cyc++;
        n_shr  += int'(shr_en);
        n_shl  += int'(norm_shl);
        n_nshr += int'(norm_shr);
        n_einc += int'(exp_inc);
        n_edec += int'(exp_dec);
        n_add  += int'(add_en);
        n_ldm  += int'(ld_mants);
        n_ldr  += int'(ld_result);
        n_ldops += int'(ld_ops && clr_mants);
        n_both += int'(norm_shr && norm_shl);
`ifdef ALIGN_FLUSH_EN
        n_fl   += int'(flush_small);
`endif
        if (cyc == 1) sw_c1 = swap;
        else if (swap) sw_hi = 1;
        else sw_lo = 1;
        if (done) begin
          done_seen++;
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("shr_en_cnt", n_shr, e.shr);
            chk("norm_shl_cnt", n_shl, e.shl);
            chk("exp_dec_cnt", n_edec, e.shl);
            chk("norm_shr_cnt", n_nshr, e.nshr);
            chk("exp_inc_cnt", n_einc, e.nshr);
            chk("add_en_cnt", n_add, e.add);
            chk("ld_mants_cnt", n_ldm, e.ldm);
            chk("ld_result_cnt", n_ldr, 1);
            chk("ld_ops_clr_cnt", n_ldops, 1);
            chk("shl_shr_overlap", n_both, 0);
            chk("swap_load", int'(sw_c1), 0);
            chk("swap_held", int'({sw_hi, sw_lo}), e.swp ? 2 : 1);
            chk("flush_cnt", n_fl, e.flush);
          end
        end
      end
    end
  end

  // Issue one operation; when push is set, queue its predicted response
  task automatic issue(input logic [8:0] d, input logic sp, input logic z,
                       input logic c, input int k, input bit push);
    exp_t e;
    int dv, mag, kk;
    bit fl;
    @(posedge clk);
    #1;
    exp_diff = d; special = sp; sum_zero = z; sum_carry = c; cur_k = k;
    start = 1'b1;
    if (push) begin
      dv  = d[8] ? int'(d) - 512 : int'(d);
      mag = (dv < 0) ? -dv : dv;
      e.swp = d[8];
      if (sp) begin
        e.done_cyc = 4; e.shr = 0; e.shl = 0; e.nshr = 0; e.add = 0; e.ldm = 0; e.flush = 0;
      end else begin
        fl = FLUSH_ON && (mag >= 27);
        e.flush = fl ? 1 : 0;
        e.shr   = fl ? 0 : ((mag > 27) ? 27 : mag);
        e.add   = 1;
        e.ldm   = 1;
        if (z)      begin kk = 0; e.nshr = 0; end
        else if (c) begin kk = 0; e.nshr = 1; end
        else        begin kk = (k > 27) ? 27 : k; e.nshr = 0; end
        e.shl      = kk;
        e.done_cyc = 6 + e.shr + kk;
      end
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int target;
    target = done_seen + 1;
    for (int i = 0; i < 200; i++) begin
      if (done_seen >= target) break;
      @(negedge clk);
    end
    chk("done_timeout", int'(done_seen >= target), 1);
    @(negedge clk);
  endtask

  function automatic int all_outs();
    int v;
    v = int'({ld_ops, clr_mants, ld_mants, swap, shr_en, add_en, norm_shr,
              norm_shl, exp_inc, exp_dec, ld_result, busy, done});
`ifdef ALIGN_FLUSH_EN
    v = v | (int'(flush_small) << 13);
`endif
    return v;
  endfunction

  initial begin
    int dv;
    logic [8:0] d;
    clear_n = 1'b0; start = 1'b0; exp_diff = 9'd0; special = 1'b0;
    sum_zero = 1'b0; sum_carry = 1'b0;
    #3;
    chk("reset_outputs", all_outs(), 0);
    #19 clear_n = 1'b1;

    issue(9'd3,    1'b0, 1'b0, 1'b0, 0,  1'b1); wait_done();
    issue(9'h1FB,  1'b0, 1'b0, 1'b0, 0,  1'b1); wait_done();
    issue(9'd100,  1'b0, 1'b0, 1'b0, 0,  1'b1); wait_done();
    issue(9'd0,    1'b0, 1'b0, 1'b1, 0,  1'b1); wait_done();
    issue(9'd0,    1'b0, 1'b0, 1'b0, 4,  1'b1); wait_done();
    issue(9'd2,    1'b0, 1'b1, 1'b0, 3,  1'b1); wait_done();
    issue(9'd7,    1'b1, 1'b0, 1'b0, 0,  1'b1); wait_done();
    issue(9'h100,  1'b0, 1'b0, 1'b0, 0,  1'b1); wait_done();
    issue(9'd27,   1'b0, 1'b0, 1'b0, 1,  1'b1); wait_done();
    issue(9'd26,   1'b0, 1'b0, 1'b0, 0,  1'b1); wait_done();
    issue(9'd0,    1'b0, 1'b0, 1'b0, 40, 1'b1); wait_done();

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        dv = int'($urandom_range(0, 24)) - 12;
        d  = 9'(dv);
      end else begin
        d = 9'($urandom_range(0, 511));
      end
      issue(d, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 6)), 1'b1);
      wait_done();
    end

    // Reset during ALIGN: operation abandoned, outputs drop immediately
    issue(9'd20, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (shr_en) break;
    end
    chk("align_reached", int'(shr_en), 1);
    #2 clear_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    @(negedge clk);
    #2 clear_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", int'(busy), 0);

    // Normal completion after reset, with a stray start mid-operation
    issue(9'd10, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("no_requeued_op", int'(busy), 0);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
